ga_debug_session_controller: RTL and testbench
==============================================

# ga_debug_session_controller

Single-clock session controller that wraps a morphologic GA core for board-level debug. It assembles origin/objective images from an incoming byte stream, releases the GA, counts generations, and streams result packets. Result packets are either a final solved/timeout packet or an optional periodic progress snapshot. It sits between the serial RX/TX byte packagers and the GA core, and replaces ad-hoc glue logic with a parametrised, timeout-aware, back-pressured state machine.

## Interface
- ImageWidth, 8, image columns
- ImageHeight, 4, image rows; Pix = ImageWidth*ImageHeight
- ErrorWidth, $clog2(Pix), GA best-error width
- IndividualWidth, 32, GA best-individual width
- CounterWidth, 16, generation counter width
- MaxGenerations, 2**CounterWidth-1, timeout limit; 1..2**CounterWidth-1
- ReportEvery, 0, progress packet every N generations; 0 = final packet only
- Derived byte counts: PixBytes=ceil(Pix/8), ErrBytes=ceil(ErrorWidth/8), CntBytes=ceil(CounterWidth/8), IndBytes=ceil(IndividualWidth/8)
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- rxByte  in  8  received byte
- rxValid  in  1  one-cycle strobe; rxByte valid
- txByte  out  8  byte to transmit
- txValid  out  1  txByte valid
- txReady  in  1  downstream accepts the byte when txValid&&txReady
- gaRst  out  1  GA core reset, high = held
- gaCycle  in  1  one-cycle strobe per completed generation, synchronous to clk
- gaBestError  in  ErrorWidth  current best error
- gaBestIndividual  in  IndividualWidth  current best individual
- origin  out  Pix  loaded origin image
- objetive  out  Pix  loaded objective image
- busy  out  1  high in RUN or SEND
- finish  out  1  high from final packet completion until the next load starts
- rxOverrun  out  1  sticky; a byte arrived outside LOAD

## Operation
- States: LOAD, RUN, SEND, SEND_FINAL.
- LOAD: gaRst=1. Each rxValid shifts rxByte into a 2*PixBytes shift register, MSB-first. The first PixBytes bytes form origin, the next PixBytes form objetive. Each image is right-aligned and its excess high bits are discarded. The first accepted byte clears finish. On the last byte, go to RUN and clear the generation counter and report counter.
- RUN: gaRst=0. On gaCycle, evaluate in this order:
  - gaBestError==0 → snapshot, status=0x81, go to SEND_FINAL; counter unchanged.
  - Otherwise counter+1. If the new value equals MaxGenerations → snapshot, status=0x82, go to SEND_FINAL.
  - Otherwise, if ReportEvery≠0 and the report counter reaches ReportEvery → snapshot, status=0x00, report counter cleared, go to SEND.
- Snapshot: latches {gaBestError, counter value after the update, gaBestIndividual}.
- Packet, byte order: status, then error, counter, individual. Each field is MSB-first and zero-padded to ErrBytes/CntBytes/IndBytes. Packet length = 1+ErrBytes+CntBytes+IndBytes.
- SEND (progress): the GA keeps running and counting on gaCycle. If a solve or timeout occurs during SEND, its snapshot and status are pended. After the last progress byte, go to SEND_FINAL with the pended data, or otherwise back to RUN. Further report triggers during SEND are dropped.
- SEND_FINAL: gaRst=1 (the GA is frozen). After the last byte, set finish=1 and go to LOAD.
- rxValid outside LOAD: the byte is discarded and rxOverrun is set. rxOverrun clears only on rst.
- origin/objetive hold their values outside LOAD and change only while shifting.

## Timing
- Reset values: state LOAD, gaRst=1, txValid=0, txByte=0, busy=0, finish=0, rxOverrun=0, origin=0, objetive=0, counters=0.
- Reset asserted mid-session aborts immediately and does not emit a packet.
- gaRst falls on the clock edge after the last load byte is registered.
- A gaCycle strobe is evaluated in the same cycle it is seen. The first packet byte appears on txValid on the next cycle.
- txByte and txValid are registered. txByte is held stable while txValid=1 and txReady=0.
- On each transfer cycle, the next byte is presented on the following cycle with no gap. After the last byte, txValid drops.
- Counters wrap only under misuse. MaxGenerations ≤ 2**CounterWidth-1 guarantees timeout before wrap.

## Test plan
- Defaults (8x4, Err 5b, Cnt 16b, Ind 32b). Load origin 0x10381000 and objetive 0x387C3810 as 8 bytes 10 38 10 00 38 7C 38 10. Expect origin/objetive set and gaRst low one cycle after the 8th byte.
- Solve: 3 gaCycle with error 4, then 1 with error 0, individual 0xDEADBEEF. Expect packet 81 00 00 03 DE AD BE EF and finish=1.
- Timeout: MaxGenerations=5, error held at 2, individual 0x12345678. Expect packet 82 02 00 05 12 34 56 78 after the 5th strobe.
- Progress: ReportEvery=2, txReady stalled 10 cycles. Expect packet 00 xx 00 02 ..., with txByte stable during the stall and the GA counting on. A solve at generation 3 during SEND yields final packet 81 00 00 03 ... immediately afterwards.
- Overrun/reset: a byte sent in RUN sets rxOverrun. rst asserted mid-SEND gives txValid=0 and gaRst=1 next cycle, with no further bytes.

Source files
------------

// File: rtl/ga_debug_session_controller.sv
// Debug session controller around a morphologic GA core: assembles the images from
// an RX byte stream, runs the GA, counts generations and streams result packets on TX.
module ga_debug_session_controller #(
   parameter int ImageWidth      = 8,
   parameter int ImageHeight     = 4,
   parameter int ErrorWidth      = $clog2(ImageWidth*ImageHeight),
   parameter int IndividualWidth = 32,
   parameter int CounterWidth    = 16,
   parameter int MaxGenerations  = 2**CounterWidth-1,
   parameter int ReportEvery     = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [7:0]                          rxByte,
   input  logic                                rxValid,
   output logic [7:0]                          txByte,
   output logic                                txValid,
   input  logic                                txReady,
   output logic                                gaRst,
   input  logic                                gaCycle,
   input  logic [ErrorWidth-1:0]               gaBestError,
   input  logic [IndividualWidth-1:0]          gaBestIndividual,
   output logic [ImageWidth*ImageHeight-1:0]   origin,
   output logic [ImageWidth*ImageHeight-1:0]   objetive,
   output logic                                busy,
   output logic                                finish,
   output logic                                rxOverrun
);

   localparam int Pix       = ImageWidth*ImageHeight;
   localparam int PixBytes  = (Pix+7)/8;
   localparam int ErrBytes  = (ErrorWidth+7)/8;
   localparam int CntBytes  = (CounterWidth+7)/8;
   localparam int IndBytes  = (IndividualWidth+7)/8;
   localparam int PktBytes  = 1+ErrBytes+CntBytes+IndBytes;
   localparam int LoadBytes = 2*PixBytes;
   localparam int ErrPadW   = ErrBytes*8;
   localparam int CntPadW   = CntBytes*8;
   localparam int IndPadW   = IndBytes*8;
   localparam int BodyW     = ErrPadW+CntPadW+IndPadW;
   localparam int LoadCntW  = $clog2(LoadBytes+1);
   localparam int TxIdxW    = $clog2(PktBytes+1);

   localparam logic [CounterWidth-1:0] MaxGen      = CounterWidth'(MaxGenerations);
   localparam logic [CounterWidth-1:0] RepTarget   = CounterWidth'(ReportEvery);
   localparam logic [LoadCntW-1:0]     LoadLastIdx = LoadCntW'(LoadBytes-1);
   localparam logic [TxIdxW-1:0]       TxLastIdx   = TxIdxW'(PktBytes-1);

   typedef enum logic [1:0] {StLoad, StRun, StSend, StSendFinal} stateT;

   stateT                   state, stateNext;
   logic [LoadBytes*8-1:0]  loadReg;
   logic [LoadCntW-1:0]     loadCnt;
   logic [CounterWidth-1:0] genCnt, repCnt;
   logic [BodyW-1:0]        pktBody, pendBody;
   logic [TxIdxW-1:0]       txIdx;
   logic                    pendValid;
   logic [7:0]              pendStatus;

   logic                    gaSolved, gaTimeout, gaDone, repHit, lastByte;
   logic [CounterWidth-1:0] genInc, genNew, repInc;
   logic [7:0]              doneStatus;
   logic [BodyW-1:0]        snapBody;

   assign origin   = Pix'(loadReg[LoadBytes*8-1 -: PixBytes*8]);
   assign objetive = Pix'(loadReg[PixBytes*8-1:0]);
   assign gaRst    = (state == StLoad) || (state == StSendFinal);
   assign busy     = (state == StRun) || (state == StSend);

   // Generation evaluation: a solve leaves the counter alone and wins over timeout/report
   always_comb begin
      genInc     = genCnt + 1'b1;
      repInc     = repCnt + 1'b1;
      gaSolved   = (gaBestError == '0);
      genNew     = gaSolved ? genCnt : genInc;
      gaTimeout  = !gaSolved && (genInc == MaxGen);
      gaDone     = gaSolved || gaTimeout;
      repHit     = (ReportEvery != 0) && (repInc == RepTarget);
      doneStatus = gaSolved ? 8'h81 : 8'h82;
      snapBody   = {ErrPadW'(gaBestError), CntPadW'(genNew), IndPadW'(gaBestIndividual)};
      lastByte   = txValid && txReady && (txIdx == TxLastIdx);
   end

   always_comb begin
      stateNext = state;
      case (state)
         StLoad:      if (rxValid && loadCnt == LoadLastIdx) stateNext = StRun;
         StRun: begin
            if (gaCycle && gaDone)      stateNext = StSendFinal;
            else if (gaCycle && repHit) stateNext = StSend;
         end
         StSend:      if (lastByte) stateNext = (pendValid || (gaCycle && gaDone)) ? StSendFinal : StRun;
         StSendFinal: if (lastByte) stateNext = StLoad;
         default:     stateNext = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= StLoad;
      else     state <= stateNext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         loadReg    <= '0;
         loadCnt    <= '0;
         genCnt     <= '0;
         repCnt     <= '0;
         pktBody    <= '0;
         pendBody   <= '0;
         pendStatus <= '0;
         pendValid  <= 1'b0;
         txIdx      <= '0;
         txByte     <= '0;
         txValid    <= 1'b0;
         finish     <= 1'b0;
         rxOverrun  <= 1'b0;
      end else begin
         if (rxValid && state != StLoad) rxOverrun <= 1'b1;
         case (state)
            StLoad: if (rxValid) begin
               loadReg <= {loadReg[LoadBytes*8-9:0], rxByte};
               if (loadCnt == '0) finish <= 1'b0;
               if (loadCnt == LoadLastIdx) begin
                  loadCnt   <= '0;
                  genCnt    <= '0;
                  repCnt    <= '0;
                  pendValid <= 1'b0;
               end else begin
                  loadCnt <= loadCnt + 1'b1;
               end
            end
            StRun: if (gaCycle) begin
               genCnt <= genNew;
               if (gaDone || repHit) begin
                  txValid <= 1'b1;
                  txByte  <= gaDone ? doneStatus : 8'h00;
                  pktBody <= snapBody;
                  txIdx   <= '0;
               end
               if (!gaDone) repCnt <= repHit ? '0 : repInc;
            end
            StSend: begin
               // A solve/timeout seen while a progress packet drains is held for afterwards
               if (gaCycle && !pendValid) begin
                  genCnt <= genNew;
                  if (gaDone) begin
                     pendValid  <= 1'b1;
                     pendStatus <= doneStatus;
                     pendBody   <= snapBody;
                  end else begin
                     repCnt <= repHit ? '0 : repInc;
                  end
               end
               if (lastByte) begin
                  pendValid <= 1'b0;
                  txIdx     <= '0;
                  if (pendValid) begin
                     txByte  <= pendStatus;
                     pktBody <= pendBody;
                  end else if (gaCycle && gaDone) begin
                     txByte  <= doneStatus;
                     pktBody <= snapBody;
                  end else begin
                     txValid <= 1'b0;
                  end
               end else if (txValid && txReady) begin
                  txByte  <= pktBody[BodyW-1 -: 8];
                  pktBody <= {pktBody[BodyW-9:0], 8'h00};
                  txIdx   <= txIdx + 1'b1;
               end
            end
            StSendFinal: begin
               if (lastByte) begin
                  txValid <= 1'b0;
                  finish  <= 1'b1;
                  txIdx   <= '0;
               end else if (txValid && txReady) begin
                  txByte  <= pktBody[BodyW-1 -: 8];
                  pktBody <= {pktBody[BodyW-9:0], 8'h00};
                  txIdx   <= txIdx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ga_debug_session_controller.sv
// Bench for ga_debug_session_controller: directed session scenarios plus random traffic,
// checked every cycle against a byte-queue model of the session.
module tb_ga_debug_session_controller;

   localparam int Mg = 5;
   localparam int Re = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rxByte = '0;
   logic        rxValid = 1'b0;
   logic [7:0]  txByte;
   logic        txValid;
   logic        txReady = 1'b0;
   logic        gaRst;
   logic        gaCycle = 1'b0;
   logic [4:0]  gaBestError = '0;
   logic [31:0] gaBestIndividual = '0;
   logic [31:0] origin, objetive;
   logic        busy, finish, rxOverrun;

   int checks = 0;
   int errors = 0;
   logic [7:0] got[$];

   ga_debug_session_controller #(
      .ImageWidth(8), .ImageHeight(4), .IndividualWidth(32), .CounterWidth(16),
      .MaxGenerations(Mg), .ReportEvery(Re)
   ) dut (
      .clk(clk), .rst(rst), .rxByte(rxByte), .rxValid(rxValid),
      .txByte(txByte), .txValid(txValid), .txReady(txReady),
      .gaRst(gaRst), .gaCycle(gaCycle), .gaBestError(gaBestError),
      .gaBestIndividual(gaBestIndividual), .origin(origin), .objetive(objetive),
      .busy(busy), .finish(finish), .rxOverrun(rxOverrun)
   );

   always #5 clk = ~clk;

   // Session model: a session is either loading, running (optionally draining a progress
   // packet), or draining its final packet; packets are plain byte queues.
   bit          mLoading = 1'b1;
   bit          mFinalPhase = 1'b0;
   bit          mFinish = 1'b0;
   bit          mOverrun = 1'b0;
   int          mLoaded = 0;
   int          mGen = 0;
   int          mRep = 0;
   logic [63:0] mImg = '0;
   logic [7:0]  mLast = '0;
   logic [7:0]  mTxQ[$];
   logic [7:0]  mPendQ[$];
   logic [7:0]  pktTmp[$];

   function automatic void buildPkt(input logic [7:0] st, input logic [4:0] e,
                                    input int g, input logic [31:0] ind);
      pktTmp = {};
      pktTmp.push_back(st);
      pktTmp.push_back({3'b000, e});
      pktTmp.push_back(g[15:8]);
      pktTmp.push_back(g[7:0]);
      for (int i = 3; i >= 0; i--) pktTmp.push_back(ind[8*i +: 8]);
   endfunction

   always @(posedge clk) begin
      bit running, sendingProg, xfer;
      if (rst) begin
         mLoading = 1'b1; mFinalPhase = 1'b0; mFinish = 1'b0; mOverrun = 1'b0;
         mLoaded = 0; mGen = 0; mRep = 0; mImg = '0; mLast = '0;
         mTxQ = {}; mPendQ = {};
      end else begin
         running     = !mLoading && !mFinalPhase;
         sendingProg = running && (mTxQ.size() != 0);
         xfer        = (mTxQ.size() != 0) && txReady;
         if (rxValid) begin
            if (mLoading) begin
               mImg = {mImg[55:0], rxByte};
               if (mLoaded == 0) mFinish = 1'b0;
               mLoaded++;
               if (mLoaded == 8) begin
                  mLoaded = 0; mLoading = 1'b0; mGen = 0; mRep = 0;
               end
            end else begin
               mOverrun = 1'b1;
            end
         end
         if (gaCycle && running && mPendQ.size() == 0) begin
            bit fin;
            logic [7:0] st;
            fin = 1'b0; st = 8'h00;
            if (gaBestError == 0) begin
               fin = 1'b1; st = 8'h81;
            end else begin
               mGen++;
               if (mGen == Mg) begin
                  fin = 1'b1; st = 8'h82;
               end else begin
                  mRep++;
                  if (mRep == Re) begin
                     mRep = 0;
                     if (!sendingProg) begin
                        buildPkt(8'h00, gaBestError, mGen, gaBestIndividual);
                        mTxQ = pktTmp;
                     end
                  end
               end
            end
            if (fin) begin
               buildPkt(st, gaBestError, mGen, gaBestIndividual);
               if (sendingProg) mPendQ = pktTmp;
               else begin
                  mTxQ = pktTmp;
                  mFinalPhase = 1'b1;
               end
            end
         end
         if (xfer) begin
            mLast = mTxQ.pop_front();
            if (mTxQ.size() == 0) begin
               if (mFinalPhase) begin
                  mFinalPhase = 1'b0; mLoading = 1'b1; mFinish = 1'b1;
               end else if (mPendQ.size() != 0) begin
                  mTxQ = mPendQ; mPendQ = {}; mFinalPhase = 1'b1;
               end
            end
         end
      end
   end

   always @(posedge clk) if (!rst && txValid && txReady) got.push_back(txByte);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] expTx;
      expTx = (mTxQ.size() != 0) ? mTxQ[0] : mLast;
      chk("txValid", 64'(txValid), 64'(mTxQ.size() != 0));
      chk("txByte", 64'(txByte), 64'(expTx));
      chk("gaRst", 64'(gaRst), 64'(mLoading || mFinalPhase));
      chk("busy", 64'(busy), 64'(!mLoading && !mFinalPhase));
      chk("finish", 64'(finish), 64'(mFinish));
      chk("rxOverrun", 64'(rxOverrun), 64'(mOverrun));
      chk("origin", 64'(origin), 64'(mImg[63:32]));
      chk("objetive", 64'(objetive), 64'(mImg[31:0]));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rxByte = b; rxValid = 1'b1;
      cyc();
      rxValid = 1'b0;
   endtask

   task automatic strobe(input logic [4:0] e, input logic [31:0] ind);
      gaBestError = e; gaBestIndividual = ind; gaCycle = 1'b1;
      cyc();
      gaCycle = 1'b0;
   endtask

   task automatic waitFinish(input int limit);
      int n;
      n = 0;
      while (!finish && n < limit) begin
         cyc();
         n++;
      end
      chk("waitFinish", 64'(finish), 64'd1);
   endtask

   task automatic loadRandom();
      for (int i = 0; i < 8; i++) sendByte(8'($urandom));
   endtask

   initial begin
      logic [7:0] img[8];
      logic [7:0] exp1[16];
      logic [7:0] exp2[8];
      img  = '{8'h10, 8'h38, 8'h10, 8'h00, 8'h38, 8'h7C, 8'h38, 8'h10};
      exp1 = '{8'h00, 8'h04, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
               8'h81, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp2 = '{8'h82, 8'h02, 8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};

      rst = 1'b1;
      cyc(); cyc();
      chk("rst txValid", 64'(txValid), 64'd0);
      chk("rst gaRst", 64'(gaRst), 64'd1);
      chk("rst origin", 64'(origin), 64'd0);
      rst = 1'b0;
      cyc();

      // Load, progress at gen 2 under a stall, solve pended during the stall
      for (int i = 0; i < 8; i++) sendByte(img[i]);
      chk("load origin", 64'(origin), 64'h10381000);
      chk("load objetive", 64'(objetive), 64'h387C3810);
      chk("load gaRst", 64'(gaRst), 64'd0);
      got.delete();
      txReady = 1'b0;
      strobe(5'd4, 32'hCAFEF00D);
      cyc();
      strobe(5'd4, 32'hCAFEF00D);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) strobe(5'd4, 32'hCAFEF00D);
         else if (i == 6) strobe(5'd0, 32'hDEADBEEF);
         else cyc();
         chk("stall txValid", 64'(txValid), 64'd1);
         chk("stall txByte", 64'(txByte), 64'h00);
      end
      txReady = 1'b1;
      waitFinish(60);
      chk("solve count", 64'(got.size()), 64'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("solve pkt", 64'(got[i]), 64'(exp1[i]));
      chk("solve gaRst", 64'(gaRst), 64'd1);

      // Timeout after 5 generations, two progress packets on the way
      got.delete();
      sendByte(8'hA5);
      chk("finish cleared", 64'(finish), 64'd0);
      for (int i = 0; i < 7; i++) sendByte(8'($urandom));
      for (int g = 0; g < 5; g++) begin
         strobe(5'd2, 32'h12345678);
         repeat (11) cyc();
      end
      waitFinish(40);
      chk("timeout count", 64'(got.size()), 64'd24);
      if (got.size() == 24) begin
         chk("progress gen2", 64'(got[3]), 64'h02);
         chk("progress gen4", 64'(got[11]), 64'h04);
         for (int i = 0; i < 8; i++) chk("timeout pkt", 64'(got[16+i]), 64'(exp2[i]));
      end

      // Overrun in RUN, then reset mid-SEND
      loadRandom();
      sendByte(8'h55);
      chk("overrun", 64'(rxOverrun), 64'd1);
      txReady = 1'b0;
      strobe(5'd3, 32'h0);
      strobe(5'd3, 32'h0);
      cyc();
      chk("in send", 64'(txValid), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort txValid", 64'(txValid), 64'd0);
      chk("abort gaRst", 64'(gaRst), 64'd1);
      chk("abort overrun", 64'(rxOverrun), 64'd0);
      txReady = 1'b1;
      repeat (5) cyc();
      chk("abort quiet", 64'(txValid), 64'd0);

      // Random traffic
      for (int n = 0; n < 5000; n++) begin
         rst              = ($urandom_range(0, 399) == 0);
         rxValid          = ($urandom_range(0, 1) == 0);
         rxByte           = 8'($urandom);
         gaCycle          = ($urandom_range(0, 2) == 0);
         gaBestError      = 5'($urandom_range(0, 7));
         gaBestIndividual = $urandom;
         txReady          = ($urandom_range(0, 3) != 0);
         cyc();
      end
      rst = 1'b0; rxValid = 1'b0; gaCycle = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
